spu_inst_streamer: RTL

Parametrised instruction streamer sitting between the instruction image store and the SPU dual-issue decode stage. It holds a loadable instruction buffer, issues `ISSUE_WIDTH` instructions per group over a valid/ready handshake, and pads the final partial group with NOPs. It counts retirements reported by the execute pipes and runs a progress watchdog, reporting `done` or `timeout`. It generalises the fixed two-instruction, fixed-depth, 1000-cycle feed/stop harness into a synthesizable, configurable block.

---
 rtl/spu_inst_streamer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/spu_inst_streamer.sv
`default_nettype none
// ============================================================================
// Module   : spu_inst_streamer
// Brief    : Buffered instruction feeder for the SPU decode stage; issues
//            fixed-width groups with NOP padding, tracks retirement and
//            runs a progress watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module spu_inst_streamer #(
    parameter int                INST_W      = 32,
    parameter int                ISSUE_WIDTH = 2,
    parameter int                DEPTH       = 128,
    parameter int                TIMEOUT     = 1000,
    parameter logic [INST_W-1:0] NOP_WORD    = 32'h4020_0000,
    parameter int                ADDR_W      = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_en,
    input  logic [ADDR_W-1:0]               load_addr,
    input  logic [INST_W-1:0]               load_data,
    input  logic                            start,
    input  logic [ADDR_W:0]                 inst_count,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [0:ISSUE_WIDTH*INST_W-1]   out_insts,
    output logic [ADDR_W+1:0]               out_pc,
    input  logic [0:ISSUE_WIDTH-1]          retire,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic                            err,
    output logic [ADDR_W:0]                 retired_count
);

    localparam int c_CNT_W = ADDR_W + 1;
    localparam int c_WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_IW     = c_CNT_W'(ISSUE_WIDTH);
    localparam logic [c_CNT_W+1:0] c_IW2    = (c_CNT_W+2)'(ISSUE_WIDTH);
    localparam logic [c_CNT_W+1:0] c_IWM1   = (c_CNT_W+2)'(ISSUE_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [c_WD_W-1:0]  c_WD_MAX = c_WD_W'(TIMEOUT);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_STREAM = 3'd1;
    localparam logic [2:0] c_S_DRAIN  = 3'd2;
    localparam logic [2:0] c_S_DONE   = 3'd3;
    localparam logic [2:0] c_S_TMO    = 3'd4;

    logic [INST_W-1:0]             r_mem [0:DEPTH-1];

    logic [2:0]                    r_state,  w_state_nxt;
    logic [c_CNT_W-1:0]            r_n,      w_n_nxt;
    logic [c_CNT_W-1:0]            r_e,      w_e_nxt;
    logic [c_CNT_W-1:0]            r_addr,   w_addr_nxt;
    logic                          r_valid,  w_valid_nxt;
    logic [0:ISSUE_WIDTH*INST_W-1] r_insts,  w_insts_nxt;
    logic [c_CNT_W-1:0]            r_cnt,    w_cnt_nxt;
    logic                          r_err,    w_err_nxt;
    logic [c_WD_W-1:0]             r_wd,     w_wd_nxt;

    logic                          w_busy;
    logic                          w_start_acc;
    logic                          w_xfer;
    logic                          w_last;
    logic [c_CNT_W-1:0]            w_n_start;
    logic [c_CNT_W-1:0]            w_e_start;
    logic [c_CNT_W+1:0]            w_n_ext;
    logic [c_CNT_W-1:0]            w_rd_addr;
    logic [c_CNT_W-1:0]            w_rd_n;
    logic [0:ISSUE_WIDTH*INST_W-1] w_rd_group;
    logic [c_CNT_W:0]              w_pop;
    logic [c_CNT_W:0]              w_sum;

    assign w_busy      = (r_state == c_S_STREAM) || (r_state == c_S_DRAIN);
    assign w_start_acc = start && !w_busy;
    assign w_xfer      = r_valid && out_ready;
    assign w_last      = ({1'b0, r_addr} + {1'b0, c_IW}) >= {1'b0, r_n};

    assign w_n_start = (inst_count > c_DEPTH) ? c_DEPTH : inst_count;
    assign w_n_ext   = {2'b00, w_n_start};
    // Expected retirements cover the NOP pads of the final partial group.
    assign w_e_start = c_CNT_W'(((w_n_ext + c_IWM1) / c_IW2) * c_IW2);

    // The next group is read ahead so it is registered when it becomes current.
    assign w_rd_addr = w_start_acc ? '0 : (r_addr + c_IW);
    assign w_rd_n    = w_start_acc ? w_n_start : r_n;

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
        logic [c_CNT_W:0] w_idx;
        assign w_idx = {1'b0, w_rd_addr} + (c_CNT_W+1)'(k);
        assign w_rd_group[k*INST_W +: INST_W] =
            (w_idx < {1'b0, w_rd_n}) ? r_mem[w_idx[ADDR_W-1:0]] : NOP_WORD;
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            w_pop = w_pop + (c_CNT_W+1)'(retire[k]);
        end
    end

    assign w_sum = {1'b0, r_cnt} + w_pop;

    always_ff @(posedge clk) begin
        if (load_en && !w_busy) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_n     <= '0;
            r_e     <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_insts <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_e     <= w_e_nxt;
            r_addr  <= w_addr_nxt;
            r_valid <= w_valid_nxt;
            r_insts <= w_insts_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_e_nxt     = r_e;
        w_addr_nxt  = r_addr;
        w_valid_nxt = r_valid;
        w_insts_nxt = r_insts;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_wd_nxt    = r_wd;
        case (r_state)
            c_S_IDLE, c_S_DONE, c_S_TMO: begin
                if (start) begin
                    w_n_nxt    = w_n_start;
                    w_e_nxt    = w_e_start;
                    w_addr_nxt = '0;
                    w_cnt_nxt  = '0;
                    w_err_nxt  = 1'b0;
                    w_wd_nxt   = '0;
                    if (w_n_start == '0) begin
                        w_state_nxt = c_S_DONE;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_state_nxt = c_S_STREAM;
                        w_valid_nxt = 1'b1;
                        w_insts_nxt = w_rd_group;
                    end
                end
            end
            c_S_STREAM, c_S_DRAIN: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = c_S_DRAIN;
                    end else begin
                        w_addr_nxt  = r_addr + c_IW;
                        w_insts_nxt = w_rd_group;
                    end
                end
                if (w_sum > {1'b0, r_e}) begin
                    w_cnt_nxt = r_e;
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_sum[c_CNT_W-1:0];
                end
                if (w_xfer || (|retire)) begin
                    w_wd_nxt = '0;
                end else begin
                    w_wd_nxt = r_wd + c_WD_W'(1);
                end
                // Completion takes priority over a same-cycle watchdog expiry.
                if (w_cnt_nxt == r_e) begin
                    w_state_nxt = c_S_DONE;
                    w_valid_nxt = 1'b0;
                end else if (w_wd_nxt == c_WD_MAX) begin
                    w_state_nxt = c_S_TMO;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign out_valid     = r_valid;
    assign out_insts     = r_insts;
    assign out_pc        = {r_addr[ADDR_W-1:0], 2'b00};
    assign busy          = w_busy;
    assign done          = (r_state == c_S_DONE);
    assign timeout       = (r_state == c_S_TMO);
    assign err           = r_err;
    assign retired_count = r_cnt;

endmodule
`default_nettype wire
